// File: rtl/sort_pkg.sv
// Shared constants for the set-less-than based sort controller.
// State encodings are plain localparams so older code can match on the raw values.
package sort_pkg;

    localparam int SORT_DEPTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/slt32.sv
// Unsigned 32-bit set-less-than: res = 1 when a < b, else 0. Purely combinational.
module slt32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res
);

    assign res = {31'd0, (a < b)};

endmodule

// File: rtl/slt_sort_ctrl.sv
// Loads up to DEPTH words, bubble-sorts them one slt32 compare per cycle, then streams them out.
// Sort takes passes*(count-1) cycles; out_data/out_last hold while out_valid & !out_ready.
module slt_sort_ctrl
    import sort_pkg::*;
#(
    parameter int DEPTH = SORT_DEPTH,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    input  logic          start,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          out_valid,
    output logic [31:0]   out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    state;
    logic [CW-1:0] idx;
    logic [CW-1:0] pass;
    logic [CW-1:0] rd;
    logic          swapped;
    logic          done_r;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] ia;
    logic [AW-1:0] ib;
    logic [31:0]   cmp_a;
    logic [31:0]   cmp_b;
    logic [31:0]   cmp_res;
    logic          swap_now;
    logic          accept;
    logic          sorting;
    logic          pass_end;
    logic          rd_last;

    // The comparator always looks at the adjacent pair at idx; results only matter in SORT.
    assign ia    = idx[AW-1:0];
    assign ib    = ia + AW'(1);
    assign cmp_a = mem[ib];
    assign cmp_b = mem[ia];

    slt32 u_slt (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res)
    );

    assign swap_now = (cmp_res == 32'd1);
    assign sorting  = (state == ST_SORT) && (count != CW'(1));
    assign pass_end = (idx == count - CW'(2));
    assign rd_last  = (rd == count - CW'(1));

    assign in_ready  = (state == ST_IDLE) && (count < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? mem[rd[AW-1:0]] : 32'd0;
    assign out_last  = out_valid && rd_last;
    assign done      = done_r;

    // Buffer is flops so a swap can write both neighbours in one edge; never reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept) begin
                mem[count[AW-1:0]] <= in_data;
            end else if (sorting && swap_now) begin
                mem[ia] <= cmp_a;
                mem[ib] <= cmp_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            idx     <= '0;
            pass    <= '0;
            rd      <= '0;
            swapped <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        count <= count + CW'(1);
                    end
                    if (start && (count != '0)) begin
                        state   <= ST_SORT;
                        idx     <= '0;
                        pass    <= '0;
                        swapped <= 1'b0;
                    end
                end
                ST_SORT: begin
                    if (count == CW'(1)) begin
                        state <= ST_DRAIN;
                    end else if (pass_end) begin
                        // A clean pass or the final permitted pass ends the sort.
                        if (!(swapped || swap_now) || (pass == count - CW'(2))) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx     <= '0;
                            pass    <= pass + CW'(1);
                            swapped <= 1'b0;
                        end
                    end else begin
                        idx     <= idx + CW'(1);
                        swapped <= swapped || swap_now;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (rd_last) begin
                            state  <= ST_IDLE;
                            count  <= '0;
                            rd     <= '0;
                            done_r <= 1'b1;
                        end else begin
                            rd <= rd + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slt_sort_ctrl.sv
// Directed bench for slt_sort_ctrl: load, sort timing, drain order, backpressure, reset mid-sort.
module tb_slt_sort_ctrl;

    localparam int DEPTH = 8;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          start;
    logic          busy;
    logic [CW-1:0] count;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_last;
    logic          out_ready;
    logic          done;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    slt_sort_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .busy      (busy),
        .count     (count),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready_load", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic run_sort(input string tag, input int exp_cycles, input bit hold_start);
        int n;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 300) begin
            n++;
            tick();
        end
        start = 1'b0;
        chk({tag, "_sort_cycles"}, n, exp_cycles);
    endtask

    task automatic drain(input string tag, input bit stall);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < exp_q.size() && guard < 200) begin
            guard++;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_data"}, out_data, exp_q[k]);
            chk({tag, "_last"}, {31'd0, out_last}, (k == exp_q.size() - 1) ? 32'd1 : 32'd0);
            tick();
            if (out_ready) k++;
        end
        out_ready = 1'b1;
        chk({tag, "_words_drained"}, k, exp_q.size());
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_done_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_done_out_data"}, out_data, 32'd0);
        chk({tag, "_done_count"}, {27'd0, count}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Mixed input, full buffer, rejected 9th word, start held through SORT
        load(32'd5); load(32'd3); load(32'd8); load(32'd1);
        load(32'd9); load(32'd2); load(32'd7); load(32'd4);
        chk("full_count", {27'd0, count}, 32'd8);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'd99;
        tick();
        in_valid = 1'b0;
        chk("ninth_rejected_count", {27'd0, count}, 32'd8);
        run_sort("mixed", 35, 1'b1);
        chk("mixed_in_ready_busy", {31'd0, in_ready}, 32'd0);
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd8, 32'd9};
        drain("mixed", 1'b0);

        // Already sorted, random backpressure on drain
        for (int w = 1; w <= 8; w++) load(32'(w));
        run_sort("sorted", 7, 1'b0);
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        drain("sorted", 1'b1);

        // Unsigned ordering
        load(32'hFFFF_FFFF); load(32'd0); load(32'h8000_0000); load(32'd1);
        run_sort("unsigned", 9, 1'b0);
        exp_q = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF};
        drain("unsigned", 1'b1);

        // Single word
        load(32'd42);
        run_sort("single", 1, 1'b0);
        exp_q = '{32'd42};
        drain("single", 1'b0);

        // start with nothing loaded
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_busy", {31'd0, busy}, 32'd0);
        chk("empty_start_out_valid", {31'd0, out_valid}, 32'd0);
        chk("empty_start_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("empty_start_busy2", {31'd0, busy}, 32'd0);

        // Reset at SORT cycle 10 of a reverse-sorted load
        for (int w = 8; w >= 1; w--) load(32'(w));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("midsort_busy", {31'd0, busy}, 32'd1);
        chk("midsort_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", {27'd0, count}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        load(32'd2); load(32'd1);
        run_sort("after_rst", 1, 1'b0);
        exp_q = '{32'd1, 32'd2};
        drain("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slt_sort_ctrl.md
# slt_sort_ctrl

Multi-cycle sorting controller that shares one `slt32` comparator across a small register buffer. It loads up to DEPTH 32-bit words over a valid/ready port, then sorts them in ascending unsigned order by bubble sort, one comparison per cycle. It then streams the sorted words out over a second valid/ready port. It sits beside the ALU datapath as a sequenced user of the set-less-than unit.

## Interface
- DEPTH, 8, buffer capacity in words (2..16)
- CW, 5, count width; must satisfy 2^CW > DEPTH
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- in_valid  in  1  load word present
- in_data  in  32  load word
- in_ready  out  1  controller accepts a load word
- start  in  1  single-cycle pulse: begin sort of loaded words
- busy  out  1  high in SORT or DRAIN
- count  out  CW  number of words currently loaded
- out_valid  out  1  sorted word present
- out_data  out  32  sorted word; 0 when out_valid=0
- out_last  out  1  marks final sorted word (qualified by out_valid)
- out_ready  in  1  consumer accepts word
- done  out  1  one-cycle pulse after last word drained

## Operation
- States: IDLE, SORT, DRAIN.
- IDLE
  - in_ready = (count < DEPTH).
  - A word is accepted when in_valid & in_ready. It is written to buf[count] and count increments.
  - start with count == 0 is ignored.
  - start with count ≥ 1 goes to SORT. A word accepted in the same cycle as start is included.
- SORT
  - Index i runs 0..count-2. Each cycle, slt32 gets A=buf[i+1], B=buf[i]. If res[0]=1, buf[i] and buf[i+1] swap at that edge.
  - Comparison is unsigned: 32'hFFFF_FFFF > 1. Equal words never swap, so the sort is stable.
  - At i = count-2, the pass ends.
  - If that pass made no swap, or pass number = count-1, go to DRAIN. Otherwise start a new pass with i=0.
  - With count == 1, SORT lasts exactly one cycle with no comparison, then goes to DRAIN.
- DRAIN
  - out_valid=1 and out_data=buf[rd], with rd starting at 0.
  - out_last = (rd == count-1).
  - On out_valid & out_ready, rd increments.
  - On the transfer of the last word: go to IDLE, count←0, rd←0, done=1 for the next cycle.
- Outside IDLE: in_ready=0, and in_valid and start are ignored.
- Reset (any state, including mid-SORT or mid-DRAIN) sets:
  - state=IDLE, count=0, i=0, pass=0, rd=0
  - in_ready=1, busy=0, out_valid=0, out_data=0, out_last=0, done=0
- Buffer contents are not cleared by reset and are never observable before being rewritten.

## Timing
- Load: one word per cycle at full throughput; in_ready is combinational from state and count.
- start sampled high at edge T: busy=1 from T+1.
- SORT duration is exactly P·(count-1) cycles, where P = passes executed (1 ≤ P ≤ count-1). For count=1 it is 1 cycle.
  - Already-sorted input, DEPTH=8: 7 cycles.
  - Reverse-sorted input, DEPTH=8: 49 cycles.
- out_valid rises in the cycle after the last SORT cycle.
- Drain: one word per cycle when out_ready is held high.
- Backpressure: while out_valid & !out_ready, out_data and out_last hold stable.
- done is high the cycle after the last out transfer; busy=0 and in_ready=1 in that same cycle.
- start cannot be accepted in the done cycle's predecessor, only from the done cycle onward.

## Structure
- Package `sort_pkg`: state encoding (IDLE=2'd0, SORT=2'd1, DRAIN=2'd2) and the default DEPTH constant.
- Sub-module: one instance of the existing `slt32` as the sole comparator. No other magnitude compare on data is permitted.
- Buffer: DEPTH×32 flops, not RAM, so two reads and two writes can happen per cycle.

## Test plan
- Load 8 words {5,3,8,1,9,2,7,4}, then start, with out_ready=1. Expect drain 1,2,3,4,5,7,8,9; out_last on 9; done one cycle later; SORT ≤49 cycles.
- Load {1,2,3,4,5,6,7,8}, then start. Expect exactly 7 SORT cycles and output identical to the input.
- Load {32'hFFFF_FFFF, 0, 32'h8000_0000, 1}. Expect output 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, confirming unsigned order.
- count=1 and count=0 boundaries:
  - Load {42}, start: 1 SORT cycle, then a single word 42 with out_last=1.
  - start with nothing loaded: stays IDLE, busy=0.
- Full buffer and ignored inputs:
  - With 8 words loaded, in_ready=0; a 9th in_valid is not accepted.
  - start held during SORT has no effect.
  - Toggling out_ready randomly in DRAIN: data holds stable while stalled, order is preserved.
- Reset mid-SORT: assert rst_n=0 for one cycle at SORT cycle 10. Next cycle expect IDLE, count=0, busy=0, out_valid=0. A fresh load {2,1} with start then yields 1, 2.
